// File: rtl/video_crop_engine.sv
// Streaming AXI4-Stream video crop stage: tracks pixel column/row, forwards only pixels
// inside a programmable window, and regenerates SOF/EOL markers for a downstream FIFO.
module video_crop_engine #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_COORD_WIDTH        = 12
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TUSER,
  input  logic [C_COORD_WIDTH-1:0]          crop_x,
  input  logic [C_COORD_WIDTH-1:0]          crop_y,
  input  logic [C_COORD_WIDTH-1:0]          crop_w,
  input  logic [C_COORD_WIDTH-1:0]          crop_h,
  output logic                              wr_en,
  input  logic                              full,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_out,
  output logic                              last_out,
  output logic                              user_out
);

  localparam int CW = C_COORD_WIDTH;
  localparam int DW = C_S_AXIS_TDATA_WIDTH;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [CW-1:0]   org_x_q, org_x_d, org_y_q, org_y_d;
  logic [CW:0]     x_end_q, x_end_d, y_end_q, y_end_d;
  logic            win_nz_q, win_nz_d;
  logic            first_pending_q, first_pending_d;
  logic            out_vld_q, out_vld_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic            user_q, user_d;

  logic            accept;
  logic            processing;
  logic            keep;
  logic [CW-1:0]   cur_x, cur_y, cur_org_x, cur_org_y;
  logic [CW:0]     cur_x_end, cur_y_end, new_x_end, new_y_end;
  logic            cur_nz, cur_first;
  logic            unused_tstrb;

  assign unused_tstrb  = ^S_AXIS_TSTRB;
  assign S_AXIS_TREADY = S_AXIS_ARESETN && (!out_vld_q || !full);
  assign wr_en         = out_vld_q && !full;
  assign data_out      = data_q;
  assign last_out      = last_q;
  assign user_out      = user_q;

  assign accept     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign processing = accept && (S_AXIS_TUSER || (state_q == ACTIVE));

  // A SOF beat is judged against the window presented alongside it, at pixel (0,0).
  assign new_x_end = ({1'b0, crop_x} + {1'b0, crop_w}) - (CW+1)'(1);
  assign new_y_end = ({1'b0, crop_y} + {1'b0, crop_h}) - (CW+1)'(1);
  assign cur_org_x = S_AXIS_TUSER ? crop_x : org_x_q;
  assign cur_org_y = S_AXIS_TUSER ? crop_y : org_y_q;
  assign cur_x_end = S_AXIS_TUSER ? new_x_end : x_end_q;
  assign cur_y_end = S_AXIS_TUSER ? new_y_end : y_end_q;
  assign cur_nz    = S_AXIS_TUSER ? ((crop_w != '0) && (crop_h != '0)) : win_nz_q;
  assign cur_x     = S_AXIS_TUSER ? '0 : x_q;
  assign cur_y     = S_AXIS_TUSER ? '0 : y_q;
  assign cur_first = S_AXIS_TUSER ? 1'b1 : first_pending_q;

  assign keep = processing && cur_nz &&
                (cur_x >= cur_org_x) && ({1'b0, cur_x} <= cur_x_end) &&
                (cur_y >= cur_org_y) && ({1'b0, cur_y} <= cur_y_end);

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    org_x_d         = org_x_q;
    org_y_d         = org_y_q;
    x_end_d         = x_end_q;
    y_end_d         = y_end_q;
    win_nz_d        = win_nz_q;
    first_pending_d = first_pending_q;
    out_vld_d       = out_vld_q;
    data_d          = data_q;
    last_d          = last_q;
    user_d          = user_q;

    if (accept && S_AXIS_TUSER) begin
      state_d  = ACTIVE;
      org_x_d  = crop_x;
      org_y_d  = crop_y;
      x_end_d  = new_x_end;
      y_end_d  = new_y_end;
      win_nz_d = (crop_w != '0) && (crop_h != '0);
    end

    if (processing) begin
      if (S_AXIS_TLAST) begin
        x_d = '0;
        y_d = (cur_y == '1) ? cur_y : cur_y + CW'(1);
      end else begin
        x_d = (cur_x == '1) ? cur_x : cur_x + CW'(1);
        y_d = cur_y;
      end
      first_pending_d = keep ? 1'b0 : cur_first;
    end

    // A newly kept beat may load in the same cycle the previous one drains.
    if (keep) begin
      out_vld_d = 1'b1;
      data_d    = S_AXIS_TDATA;
      last_d    = ({1'b0, cur_x} == cur_x_end) || S_AXIS_TLAST;
      user_d    = cur_first;
    end else if (wr_en) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q         <= WAIT_SOF;
      x_q             <= '0;
      y_q             <= '0;
      org_x_q         <= '0;
      org_y_q         <= '0;
      x_end_q         <= '0;
      y_end_q         <= '0;
      win_nz_q        <= 1'b0;
      first_pending_q <= 1'b0;
      out_vld_q       <= 1'b0;
      data_q          <= '0;
      last_q          <= 1'b0;
      user_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      org_x_q         <= org_x_d;
      org_y_q         <= org_y_d;
      x_end_q         <= x_end_d;
      y_end_q         <= y_end_d;
      win_nz_q        <= win_nz_d;
      first_pending_q <= first_pending_d;
      out_vld_q       <= out_vld_d;
      data_q          <= data_d;
      last_q          <= last_d;
      user_q          <= user_d;
    end
  end

endmodule

// File: tb/tb_video_crop_engine.sv
// Self-checking bench for video_crop_engine: directed frame table, stall/reset/resync
// sequences, and randomized frames checked against a window-rule reference model.
module tb_video_crop_engine;

  localparam int DW = 32;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [DW-1:0] tData = '0;
  logic [DW/8-1:0] tStrb = '1;
  logic          tValid = 1'b0;
  logic          tReady;
  logic          tLast = 1'b0;
  logic          tUser = 1'b0;
  logic [CW-1:0] cropX = '0, cropY = '0, cropW = '0, cropH = '0;
  logic          wrEn;
  logic          full = 1'b0;
  logic [DW-1:0] dataOut;
  logic          lastOut;
  logic          userOut;

  always #5 clk = ~clk;

  video_crop_engine #(.C_S_AXIS_TDATA_WIDTH(DW), .C_COORD_WIDTH(CW)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstN), .S_AXIS_TDATA(tData), .S_AXIS_TSTRB(tStrb),
    .S_AXIS_TVALID(tValid), .S_AXIS_TREADY(tReady), .S_AXIS_TLAST(tLast), .S_AXIS_TUSER(tUser),
    .crop_x(cropX), .crop_y(cropY), .crop_w(cropW), .crop_h(cropH),
    .wr_en(wrEn), .full(full), .data_out(dataOut), .last_out(lastOut), .user_out(userOut)
  );

  typedef struct { logic [DW-1:0] data; bit last; bit user; int acc; } exp_t;
  typedef struct {
    int junk; int cx; int cy; int cw; int ch; int fw; int fh;
    int abortAt; int stallData; int expWrites; int expFirst; bit lat;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[7];
  int   testsRun = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rowWrites = 0;
  logic [DW-1:0] firstData;
  bit   firstUser;
  bit   checkLat = 1'b0;
  int   stallTrigger = -1;
  int   stallCnt = 0;
  bit   stallActive = 1'b0;
  bit   randFull = 1'b0;

  // Reference model: window latched at SOF, position advanced by the TLAST rules.
  bit   mActive = 1'b0;
  bit   mFirst = 1'b0;
  int   mx, my, mw, mh, mCol, mRow;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, longint actual, longint expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelBeat(logic [DW-1:0] data, bit last, bit user);
    bit keep;
    exp_t e;
    if (user) begin
      mActive = 1'b1; mFirst = 1'b1;
      mx = int'(cropX); my = int'(cropY); mw = int'(cropW); mh = int'(cropH);
      mCol = 0; mRow = 0;
    end
    if (!mActive) return;
    keep = (mw != 0) && (mh != 0) && (mCol >= mx) && (mCol < mx + mw) &&
           (mRow >= my) && (mRow < my + mh);
    if (keep) begin
      e.data = data; e.last = (mCol == mx + mw - 1) || last; e.user = mFirst; e.acc = cyc;
      expQ.push_back(e);
      mFirst = 1'b0;
    end
    if (last) begin
      mCol = 0;
      mRow = (mRow < 4095) ? mRow + 1 : 4095;
    end else begin
      mCol = (mCol < 4095) ? mCol + 1 : 4095;
    end
  endtask

  // Present one beat and hold it until the DUT takes it; called at posedge+1.
  task automatic applyStimulus(logic [DW-1:0] data, bit last, bit user, int gapMax);
    int wait_n;
    if (gapMax > 0 && $urandom_range(0, 3) == 0) begin
      tValid = 1'b0;
      repeat ($urandom_range(1, gapMax)) begin @(posedge clk); #1; end
    end
    tValid = 1'b1; tData = data; tLast = last; tUser = user;
    wait_n = 0;
    forever begin
      @(negedge clk);
      if (tReady) begin
        modelBeat(data, last, user);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      wait_n++;
      if (wait_n > 200) begin
        checkOutput("acceptTimeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic sendFrame(int fw, int fh, int abortAt, int gapMax, bit randData, bit randCrop);
    for (int i = 0; i < fw * fh; i++) begin
      if (abortAt >= 0 && i >= abortAt) break;
      applyStimulus(randData ? DW'($urandom) : DW'((i / fw) * fw + (i % fw)),
                    (i % fw) == fw - 1, i == 0, gapMax);
      if (i == 0 && randCrop) begin
        cropX = CW'($urandom); cropY = CW'($urandom);
        cropW = CW'($urandom); cropH = CW'($urandom);
      end
    end
    tValid = 1'b0; tUser = 1'b0; tLast = 1'b0;
  endtask

  task automatic drainRow(string name, int expWrites, int expFirst);
    int n;
    tValid = 1'b0;
    randFull = 1'b0;
    n = 0;
    while ((expQ.size() != 0 || wrEn) && n < 200) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    checkOutput({name, "_drained"}, expQ.size(), 0);
    if (expWrites >= 0) checkOutput({name, "_writes"}, rowWrites, expWrites);
    if (expFirst >= 0 && rowWrites > 0) begin
      checkOutput({name, "_firstData"}, firstData, expFirst);
      checkOutput({name, "_firstUser"}, firstUser, 1);
    end
    rowWrites = 0;
  endtask

  // Output monitor: every FIFO write is scored against the model's queue.
  initial forever begin
    @(negedge clk);
    if (stallActive) begin
      checkOutput("stallWrEn", wrEn, 0);
      checkOutput("stallReady", tReady, 0);
      if (expQ.size() != 0) checkOutput("stallHold", dataOut, expQ[0].data);
    end
    if (wrEn) begin
      if (rowWrites == 0) begin firstData = dataOut; firstUser = userOut; end
      rowWrites++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", dataOut, 32'hffffffff);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("data", dataOut, e.data);
        checkOutput("last", lastOut, e.last);
        checkOutput("user", userOut, e.user);
        if (checkLat) checkOutput("latency", cyc, e.acc + 1);
      end
      if (stallTrigger >= 0 && dataOut == DW'(stallTrigger)) begin
        stallCnt = 5;
        stallTrigger = -1;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (stallCnt > 0) begin
      full = 1'b1; stallActive = 1'b1; stallCnt--;
    end else begin
      stallActive = 1'b0;
      full = randFull ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin
    vecs[0] = '{5, 0, 0, 0, 3, 8, 4, -1, -1, 0, -1, 1};
    vecs[1] = '{0, 0, 0, 1, 1, 8, 4, -1, -1, 1, 0, 1};
    vecs[2] = '{0, 2, 1, 3, 2, 8, 4, -1, -1, 6, 10, 1};
    vecs[3] = '{0, 2, 1, 3, 2, 8, 4, -1, 11, 6, 10, 0};
    vecs[4] = '{0, 6, 2, 5, 5, 8, 4, -1, -1, 4, 22, 1};
    vecs[5] = '{0, 2, 1, 3, 2, 8, 4, 19, -1, 4, 10, 1};
    vecs[6] = '{0, 1, 0, 2, 2, 8, 4, -1, -1, 4, 1, 1};

    #12;
    checkOutput("rstReady", tReady, 0);
    checkOutput("rstWrEn", wrEn, 0);
    checkOutput("rstData", dataOut, 0);
    checkOutput("rstLast", lastOut, 0);
    checkOutput("rstUser", userOut, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    #1;
    checkOutput("postRstReady", tReady, 1);

    for (int v = 0; v < 7; v++) begin
      checkLat = vecs[v].lat;
      for (int j = 0; j < vecs[v].junk; j++) applyStimulus(DW'(32'hdead0000 + j), j == 2, 1'b0, 0);
      cropX = CW'(vecs[v].cx); cropY = CW'(vecs[v].cy);
      cropW = CW'(vecs[v].cw); cropH = CW'(vecs[v].ch);
      stallTrigger = vecs[v].stallData;
      sendFrame(vecs[v].fw, vecs[v].fh, vecs[v].abortAt, 0, 1'b0, 1'b0);
      if (vecs[v].abortAt < 0) drainRow($sformatf("vec%0d", v), vecs[v].expWrites, vecs[v].expFirst);
      else begin
        @(posedge clk); #1;
        drainRow($sformatf("vec%0d", v), vecs[v].expWrites, vecs[v].expFirst);
      end
    end

    // Reset mid-row while a kept pixel sits in the output register.
    checkLat = 1'b1;
    cropX = 2; cropY = 1; cropW = 3; cropH = 2;
    sendFrame(8, 4, 12, 0, 1'b0, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstWrEn", wrEn, 0);
    checkOutput("midRstData", dataOut, 0);
    checkOutput("midRstLast", lastOut, 0);
    checkOutput("midRstUser", userOut, 0);
    checkOutput("midRstReady", tReady, 0);
    expQ.delete();
    mActive = 1'b0;
    rowWrites = 0;
    repeat (2) begin @(posedge clk); #1; end
    rstN = 1'b1;
    #1;
    checkOutput("midRstReadyRel", tReady, 1);
    for (int j = 0; j < 3; j++) applyStimulus(DW'(32'hbeef0000 + j), 1'b0, 1'b0, 0);
    sendFrame(8, 4, -1, 0, 1'b0, 1'b0);
    drainRow("afterRst", 6, 10);

    // Randomized frames with gaps, back-pressure, aborts and mid-frame window changes.
    checkLat = 1'b0;
    for (int f = 0; f < 30; f++) begin
      int fw, fh, abortAt;
      randFull = 1'b1;
      if ($urandom_range(0, 4) == 0)
        for (int j = 0; j < $urandom_range(1, 3); j++) applyStimulus(DW'($urandom), $urandom_range(0, 1), 1'b0, 2);
      cropX = CW'($urandom_range(0, 9)); cropY = CW'($urandom_range(0, 5));
      cropW = CW'($urandom_range(0, 8)); cropH = CW'($urandom_range(0, 5));
      fw = $urandom_range(1, 10); fh = $urandom_range(1, 6);
      abortAt = (fw * fh > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, fw * fh - 1) : -1;
      sendFrame(fw, fh, abortAt, 2, 1'b1, 1'b1);
    end
    drainRow("random", -1, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got 1, expected 0");
    $fatal(1, "[TB] timeout");
  end

endmodule
